// File: rtl/otp_generator.sv
// One-time-pad generator: Magma (GOST R 34.12-2015) in CTR mode.
// Each pad is 64 ciphertext blocks streamed out as 1024 nibbles to an external RAM.
//
// state | meaning
// IDLE  | waiting for istart, no pad valid
// ENC   | 32 Magma rounds on the current counter block, one round per cycle
// WRITE | 16 nibble writes of the finished block, MSB nibble first
// DONE  | pad complete in RAM, odone held until inew_otp or istart
module otp_generator #(
  parameter int BLOCKS = 64
) (
  input  logic         iclk,
  input  logic         irst,
  input  logic         istart,
  input  logic         inew_otp,
  input  logic [255:0] ikey,
  input  logic [31:0]  iIV,
  output logic [9:0]   oaddr,
  output logic [3:0]   owdata,
  output logic         owrite_en,
  output logic         odone
);

  localparam int BW = $clog2(BLOCKS);

  // S-boxes pi0..pi7, entry v stored at bits [4v+3:4v]
  localparam logic [7:0][63:0] SBOX = {
    64'h2BC96AF43850DE71,  // pi7
    64'h73AD0B4FC19652E8,  // pi6
    64'h0E34187BAC296FD5,  // pi5
    64'hC24BE390D618A5F7,  // pi4
    64'hB9E35A076F4D128C,  // pi3
    64'h069C471EDAF2853B,  // pi2
    64'hF0DB74E1C5A93286,  // pi1
    64'h1F307D8E9B5A264C   // pi0
  };

  typedef enum logic [1:0] {IDLE, ENC, WRITE, DONE} state_t;

  state_t          state, state_next;
  logic [63:0]     ctr;
  logic            ctr_loaded;
  logic [31:0]     a1, a0;
  logic [4:0]      round_cnt;
  logic [3:0]      nib_cnt;
  logic [BW-1:0]   blk_cnt;
  logic            done_r;
  logic            start_accept;
  logic            last_nib;
  logic            last_blk;
  logic [7:0][31:0] key_words;
  logic [31:0]     round_key;
  logic [31:0]     g_out;
  logic [63:0]     ct_shifted;

  function automatic logic [31:0] magma_g(input logic [31:0] x);
    logic [31:0] s;
    logic [3:0]  v;
    s = '0;
    for (int j = 0; j < 8; j++) begin
      v = x[4*j +: 4];
      s[4*j +: 4] = SBOX[j][{v, 2'b00} +: 4];
    end
    return {s[20:0], s[31:21]};
  endfunction

  // K1 sits in the top word of ikey, so key_words[7] = K1 ... key_words[0] = K8.
  // Rounds 0..23 use K1..K8 cyclically, rounds 24..31 run K8..K1.
  assign key_words    = ikey;
  assign round_key    = (round_cnt[4:3] == 2'b11) ? key_words[round_cnt[2:0]]
                                                  : key_words[~round_cnt[2:0]];
  assign g_out        = magma_g(a0 + round_key);

  assign start_accept = istart && (state == IDLE || state == DONE);
  assign last_nib     = (nib_cnt == 4'd15);
  assign last_blk     = (blk_cnt == BW'(BLOCKS - 1));

  // FSM state register
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (istart) state_next = ENC;
      ENC:   if (round_cnt == 5'd31) state_next = WRITE;
      WRITE: if (last_nib) state_next = last_blk ? DONE : ENC;
      DONE: begin
        if (istart)        state_next = ENC;
        else if (inew_otp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Cipher datapath, counter and block/nibble/round indices
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      ctr        <= '0;
      ctr_loaded <= 1'b0;
      a1         <= '0;
      a0         <= '0;
      round_cnt  <= '0;
      nib_cnt    <= '0;
      blk_cnt    <= '0;
      done_r     <= 1'b0;
    end else if (start_accept) begin
      if (!ctr_loaded) begin
        ctr        <= {iIV, 32'h0};
        ctr_loaded <= 1'b1;
        a1         <= iIV;
        a0         <= 32'h0;
      end else begin
        a1 <= ctr[63:32];
        a0 <= ctr[31:0];
      end
      round_cnt <= '0;
      nib_cnt   <= '0;
      blk_cnt   <= '0;
      done_r    <= 1'b0;
    end else begin
      unique case (state)
        ENC: begin
          round_cnt <= round_cnt + 5'd1;
          // final round leaves a0 in place instead of swapping
          if (round_cnt == 5'd31) begin
            a1 <= a1 ^ g_out;
          end else begin
            a1 <= a0;
            a0 <= a1 ^ g_out;
          end
        end
        WRITE: begin
          nib_cnt <= nib_cnt + 4'd1;
          if (last_nib) begin
            // ciphertext is fully written; load the next counter value as plaintext
            ctr      <= ctr + 64'd1;
            {a1, a0} <= ctr + 64'd1;
            blk_cnt  <= blk_cnt + 1'b1;
            if (last_blk) done_r <= 1'b1;
          end
        end
        DONE: if (inew_otp) done_r <= 1'b0;
        default: ;
      endcase
    end
  end

  assign ct_shifted = {a1, a0} << {nib_cnt, 2'b00};
  assign owrite_en  = (state == WRITE);
  assign oaddr      = owrite_en ? {blk_cnt, nib_cnt} : '0;
  assign owdata     = owrite_en ? ct_shifted[63:60] : '0;
  assign odone      = done_r;

endmodule

// File: tb/tb_otp_generator.sv
// Bench for otp_generator: table of pads with model-derived expectations plus
// hand sequences for second pad, DONE hold, mid-pad istart and reset abort.
module tb_otp_generator;

  logic         iclk = 1'b0;
  logic         irst;
  logic         istart;
  logic         inew_otp;
  logic [255:0] ikey;
  logic [31:0]  iIV;
  logic [9:0]   oaddr;
  logic [3:0]   owdata;
  logic         owrite_en;
  logic         odone;

  int errors = 0;
  int checks = 0;

  logic [13:0] caps[$];

  localparam logic [255:0] KAT_KEY =
    256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

  localparam int SB [8][16] = '{
    '{12, 4, 6, 2,10, 5,11, 9,14, 8,13, 7, 0, 3,15, 1},
    '{ 6, 8, 2, 3, 9,10, 5,12, 1,14, 4, 7,11,13, 0,15},
    '{11, 3, 5, 8, 2,15,10,13,14, 1, 7, 4,12, 9, 6, 0},
    '{12, 8, 2, 1,13, 4,15, 6, 7, 0,10, 5, 3,14, 9,11},
    '{ 7,15, 5,10, 8, 1, 6,13, 0, 9, 3,14,11, 4, 2,12},
    '{ 5,13,15, 6, 9, 2,12,10,11, 7, 8, 1, 4, 3,14, 0},
    '{ 8,14, 2, 5, 6, 9, 1,12,15, 4,11, 0,13,10, 3, 7},
    '{ 1, 7,14,13, 0, 5, 8, 3, 4,15,10, 6, 9,12,11, 2}
  };

  typedef struct {
    logic [255:0] key;
    logic [31:0]  iv;
    logic [63:0]  exp_blk0;
  } vec_t;

  vec_t tbl[4];

  otp_generator dut (
    .iclk      (iclk),
    .irst      (irst),
    .istart    (istart),
    .inew_otp  (inew_otp),
    .ikey      (ikey),
    .iIV       (iIV),
    .oaddr     (oaddr),
    .owdata    (owdata),
    .owrite_en (owrite_en),
    .odone     (odone)
  );

  always #5 iclk = ~iclk;

  always @(negedge iclk) begin
    if (owrite_en) caps.push_back({oaddr, owdata});
  end

  function automatic logic [63:0] magma(input logic [255:0] key, input logic [63:0] blk);
    logic [31:0] a1, a0, t, s, k;
    int ki;
    a1 = blk[63:32];
    a0 = blk[31:0];
    for (int i = 0; i < 32; i++) begin
      ki = (i < 24) ? (i % 8) : (7 - i % 8);
      k  = key[255 - 32*ki -: 32];
      t  = a0 + k;
      s  = 0;
      for (int j = 0; j < 8; j++)
        s = s | (32'(SB[j][(t >> (4*j)) & 32'hf]) << (4*j));
      s = (s << 11) | (s >> 21);
      if (i < 31) begin
        t  = a0;
        a0 = a1 ^ s;
        a1 = t;
      end else begin
        a1 = a1 ^ s;
      end
    end
    return {a1, a0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    irst = 1'b0;
    istart = 1'b0;
    inew_otp = 1'b0;
    repeat (2) @(posedge iclk);
    #1;
    chk("reset_outputs", {50'd0, oaddr, owdata}, 64'd0);
    chk("reset_ctrl", {62'd0, owrite_en, odone}, 64'd0);
    @(negedge iclk);
    irst = 1'b1;
  endtask

  task automatic run_pad(input logic [63:0] base, input bit with_new, input int mid_at,
                         input string tag);
    int n, abad, dbad;
    logic [63:0] ct;
    caps.delete();
    @(negedge iclk);
    istart = 1'b1;
    inew_otp = with_new;
    @(posedge iclk);
    #1;
    istart = 1'b0;
    inew_otp = 1'b0;
    n = 0;
    while (n < 3200) begin
      @(posedge iclk);
      #1;
      n++;
      istart = (n == mid_at);
      if (odone) break;
    end
    istart = 1'b0;
    chk({tag, " done_latency"}, 64'(n), 64'd3072);
    chk({tag, " write_count"}, 64'(caps.size()), 64'd1024);
    abad = 0;
    dbad = 0;
    ct = '0;
    for (int i = 0; i < caps.size(); i++) begin
      if (caps[i][13:4] != 10'(i)) abad++;
      if (i % 16 == 0) ct = magma(ikey, base + 64'(i / 16));
      if (caps[i][3:0] != 4'(ct >> (60 - 4*(i % 16)))) dbad++;
    end
    chk({tag, " addr_order_bad"}, 64'(abad), 64'd0);
    chk({tag, " data_bad"}, 64'(dbad), 64'd0);
  endtask

  initial begin
    logic [63:0] w;
    logic [63:0] base;
    int n;
    irst = 1'b0;
    istart = 1'b0;
    inew_otp = 1'b0;
    ikey = KAT_KEY;
    iIV = 32'h0;

    chk("model_kat", magma(KAT_KEY, 64'hfedcba9876543210), 64'h4ee901e5c2d8ca3d);

    tbl[0] = '{KAT_KEY, 32'h12345678, magma(KAT_KEY, 64'h1234567800000000)};
    tbl[1] = '{KAT_KEY, 32'hb97b7f46, magma(KAT_KEY, 64'hb97b7f4600000000)};
    for (int v = 2; v < 4; v++) begin
      tbl[v].key = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
      tbl[v].iv  = $urandom;
      tbl[v].exp_blk0 = magma(tbl[v].key, {tbl[v].iv, 32'h0});
    end

    for (int v = 0; v < 4; v++) begin
      ikey = tbl[v].key;
      iIV  = tbl[v].iv;
      do_reset();
      run_pad({tbl[v].iv, 32'h0}, 1'b0, -1, $sformatf("vec%0d", v));
      w = '0;
      for (int i = 0; i < 16 && i < caps.size(); i++) w = {w[59:0], caps[i][3:0]};
      chk($sformatf("vec%0d blk0", v), w, tbl[v].exp_blk0);
    end

    base = {tbl[3].iv, 32'h0};

    // second pad continues the counter after inew_otp
    @(negedge iclk);
    inew_otp = 1'b1;
    @(posedge iclk);
    #1;
    inew_otp = 1'b0;
    chk("new_otp_clears", {63'd0, odone}, 64'd0);
    run_pad(base + 64'd64, 1'b0, -1, "pad2");

    // DONE holds without inew_otp and writes nothing
    caps.delete();
    repeat (50) @(posedge iclk);
    #1;
    chk("done_hold", {63'd0, odone}, 64'd1);
    chk("done_no_writes", 64'(caps.size()), 64'd0);

    // istart together with inew_otp starts a new pad; a mid-pad istart is ignored
    run_pad(base + 64'd128, 1'b1, 700, "pad3");

    caps.delete();
    @(negedge iclk);
    inew_otp = 1'b1;
    @(posedge iclk);
    #1;
    inew_otp = 1'b0;
    chk("idle_after_new", {63'd0, odone}, 64'd0);
    repeat (20) @(posedge iclk);
    #1;
    chk("idle_no_writes", 64'(caps.size()), 64'd0);

    // reset in the middle of a pad aborts; next pad reloads from iIV
    caps.delete();
    @(negedge iclk);
    istart = 1'b1;
    @(posedge iclk);
    #1;
    istart = 1'b0;
    n = 0;
    while (caps.size() < 500 && n < 2000) begin
      @(posedge iclk);
      #1;
      n++;
    end
    chk("abort_reached_500", {63'd0, caps.size() >= 500}, 64'd1);
    irst = 1'b0;
    #1;
    chk("abort_outputs", {50'd0, oaddr, owdata}, 64'd0);
    chk("abort_ctrl", {62'd0, owrite_en, odone}, 64'd0);
    @(negedge iclk);
    irst = 1'b1;
    iIV = 32'h0badf00d;
    run_pad({32'h0badf00d, 32'h0}, 1'b0, -1, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
